// File: rtl/mem_req_if.sv
// mem_req_if: bundles the cache-side request/response signals and the AXI
// bridge request port used by mem_req_arbiter.
//   slave  modport : the arbiter's view (requests and bridge responses in,
//                    grants, done pulses, read data and bridge request out).
//   master modport : the surrounding caches and bridge (mirror directions).
// Parameter BLOCK_W : cache line width in bits.
interface mem_req_if #(
  parameter int BLOCK_W = 128
);
  // instruction cache
  logic               ic_req;
  logic               ic_blk;
  logic [31:0]        ic_addr;
  logic               ic_gnt;
  logic               ic_done;
  // data cache
  logic               dc_req;
  logic               dc_wr;
  logic               dc_blk;
  logic [31:0]        dc_addr;
  logic [BLOCK_W-1:0] dc_wblock;
  logic [31:0]        dc_wword;
  logic [3:0]         dc_wstrb;
  logic               dc_gnt;
  logic               dc_done;
  // shared read data
  logic [BLOCK_W-1:0] rblock;
  logic [31:0]        rword;
  // bridge
  logic [2:0]         bus_req;
  logic [31:0]        bus_addr;
  logic [BLOCK_W-1:0] bus_wblock;
  logic [31:0]        bus_wword;
  logic [3:0]         bus_wstrb;
  logic               bus_ready;
  logic               bus_finish;
  logic [BLOCK_W-1:0] bus_rblock;
  logic [31:0]        bus_rword;
  // status
  logic               busy;

  modport slave (
    input  ic_req, ic_blk, ic_addr,
    input  dc_req, dc_wr, dc_blk, dc_addr, dc_wblock, dc_wword, dc_wstrb,
    input  bus_ready, bus_finish, bus_rblock, bus_rword,
    output ic_gnt, ic_done, dc_gnt, dc_done, rblock, rword,
    output bus_req, bus_addr, bus_wblock, bus_wword, bus_wstrb, busy
  );

  modport master (
    output ic_req, ic_blk, ic_addr,
    output dc_req, dc_wr, dc_blk, dc_addr, dc_wblock, dc_wword, dc_wstrb,
    output bus_ready, bus_finish, bus_rblock, bus_rword,
    input  ic_gnt, ic_done, dc_gnt, dc_done, rblock, rword,
    input  bus_req, bus_addr, bus_wblock, bus_wword, bus_wstrb, busy
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates icache and dcache miss/uncached requests onto
// the single AXI bridge request port, one outstanding transaction at a time.
// Sequence: IDLE (grant + latch) -> ISSUE (drive bus_req until bus_ready)
// -> WAIT (until bus_finish) -> DONE (one-cycle done pulse) -> IDLE.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   arb  : mem_req_if.slave bundle (cache ports, read data, bridge port, busy)
// Parameters:
//   BLOCK_W    : cache line width (multiple of 32), must match the interface
//   STARVE_LIM : consecutive dcache tie wins allowed while icache waits (1..255)
// Build option:
//   ARB_RR_EN  : when defined, ties are resolved round-robin instead of
//                fixed dcache priority with icache aging.
module mem_req_arbiter #(
  parameter int BLOCK_W    = 128,
  parameter int STARVE_LIM = 8
) (
  input  logic      clk,
  input  logic      rst,
  mem_req_if.slave  arb
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               owner_dc_q;
  logic [2:0]         type_q;
  logic [31:0]        addr_q;
  logic [BLOCK_W-1:0] wblock_q;
  logic [31:0]        wword_q;
  logic [3:0]         wstrb_q;
  logic [BLOCK_W-1:0] rblock_q;
  logic [31:0]        rword_q;

  logic idle;
  logic ic_pick;   // icache wins a tie this cycle
  logic ic_win;
  logic dc_win;
  logic capture;

  assign idle = (state_q == S_IDLE);

`ifdef ARB_RR_EN
  // last_ic_q = 1 means icache was granted last; resets to icache so the
  // first tie goes to dcache.
  logic last_ic_q;
  assign ic_pick = !last_ic_q;
`else
  localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIM);
  logic [7:0] starve_q;
  assign ic_pick = (starve_q >= STARVE_LIM_C);
`endif

  assign ic_win = idle && arb.ic_req && (!arb.dc_req || ic_pick);
  assign dc_win = idle && arb.dc_req && !ic_win;

  // Read data is taken on the finish beat, including the fast path where
  // ready and finish coincide in ISSUE.
  assign capture = ((state_q == S_ISSUE) && arb.bus_ready && arb.bus_finish) ||
                   ((state_q == S_WAIT) && arb.bus_finish);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ic_win || dc_win) state_d = S_ISSUE;
      S_ISSUE: if (arb.bus_ready) state_d = arb.bus_finish ? S_DONE : S_WAIT;
      S_WAIT:  if (arb.bus_finish) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_dc_q <= 1'b0;
      type_q     <= 3'd0;
      addr_q     <= 32'd0;
      wblock_q   <= '0;
      wword_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      rblock_q   <= '0;
      rword_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (ic_win) begin
        owner_dc_q <= 1'b0;
        type_q     <= arb.ic_blk ? 3'd2 : 3'd1;
        addr_q     <= arb.ic_addr;
      end else if (dc_win) begin
        owner_dc_q <= 1'b1;
        // {wr,blk}: 00 rd word, 01 rd block, 10 wr word, 11 wr block
        type_q     <= {1'b0, arb.dc_wr, arb.dc_blk} + 3'd1;
        addr_q     <= arb.dc_addr;
        wblock_q   <= arb.dc_wblock;
        wword_q    <= arb.dc_wword;
        wstrb_q    <= arb.dc_wstrb;
      end
      if (capture) begin
        rblock_q <= arb.bus_rblock;
        rword_q  <= arb.bus_rword;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ic_q <= 1'b1;
    end else if (ic_win) begin
      last_ic_q <= 1'b1;
    end else if (dc_win) begin
      last_ic_q <= 1'b0;
    end
  end
`else
  // Aging: count dcache grants that made icache wait; any icache grant or an
  // IDLE cycle without an icache request restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 8'd0;
    end else if (ic_win) begin
      starve_q <= 8'd0;
    end else if (dc_win && arb.ic_req) begin
      if (starve_q != 8'hFF) starve_q <= starve_q + 8'd1;
    end else if (idle && !arb.ic_req) begin
      starve_q <= 8'd0;
    end
  end
`endif

  assign arb.ic_gnt     = ic_win;
  assign arb.dc_gnt     = dc_win;
  assign arb.ic_done    = (state_q == S_DONE) && !owner_dc_q;
  assign arb.dc_done    = (state_q == S_DONE) && owner_dc_q;
  assign arb.rblock     = rblock_q;
  assign arb.rword      = rword_q;
  assign arb.bus_req    = (state_q == S_ISSUE) ? type_q : 3'd0;
  assign arb.bus_addr   = addr_q;
  assign arb.bus_wblock = wblock_q;
  assign arb.bus_wword  = wword_q;
  assign arb.bus_wstrb  = wstrb_q;
  assign arb.busy       = !idle;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized self-checking bench for mem_req_arbiter.
// A behavioural model predicts grants, bus requests and done pulses from the
// arbitration rules; expected bus operations and completions are queued and
// popped by an independent monitor when the DUT presents them.
module tb_mem_req_arbiter;
  localparam int BW  = 128;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_req_if #(.BLOCK_W(BW)) bif ();

  mem_req_arbiter #(.BLOCK_W(BW), .STARVE_LIM(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    typ;
    logic [31:0]   addr;
    logic [BW-1:0] wblock;
    logic [31:0]   wword;
    logic [3:0]    wstrb;
  } bus_op_t;

  typedef struct {
    bit            dc;
    logic [2:0]    typ;
    logic [BW-1:0] rblock;
    logic [31:0]   rword;
  } done_t;

  int n_checks = 0;
  int n_fail   = 0;

  bus_op_t bus_q[$];
  done_t   done_q[$];
  bit      gnt_log[$];
  bit      tie_logging = 0;

  // reference model state
  bit      m_active = 0, m_acc = 0, m_fin = 0, m_owner_dc = 0, m_last_ic = 1;
  int      m_starve = 0;
  bus_op_t m_op;
  int      m_ic_gnts = 0, m_dc_gnts = 0;

  // stimulus configuration
  int ic_rate = 0, dc_rate = 0;
  int cfg_rdy = -1, cfg_fin = -1, cfg_fast = -1;
  bit cfg_noise = 0, cfg_rdata_fixed = 0;
  int ic_taken = 0, dc_taken = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one step per cycle ----------------
  always @(negedge clk) begin
    bit exp_ic, exp_dc, pick_ic, fin_now;
    logic [2:0] exp_req;
    done_t d;
    exp_ic = 0; exp_dc = 0; fin_now = 0;
    if (rst) begin
      chk("rst_busy",    BW'(bif.busy),     '0);
      chk("rst_ic_gnt",  BW'(bif.ic_gnt),   '0);
      chk("rst_dc_gnt",  BW'(bif.dc_gnt),   '0);
      chk("rst_ic_done", BW'(bif.ic_done),  '0);
      chk("rst_dc_done", BW'(bif.dc_done),  '0);
      chk("rst_bus_req", BW'(bif.bus_req),  '0);
      chk("rst_bus_addr", BW'(bif.bus_addr), '0);
      chk("rst_rblock",  bif.rblock,        '0);
      chk("rst_rword",   BW'(bif.rword),    '0);
      m_active = 0; m_acc = 0; m_fin = 0; m_starve = 0; m_last_ic = 1;
      bus_q.delete();
      done_q.delete();
    end else begin
      if (!m_active) begin
`ifdef ARB_RR_EN
        pick_ic = !m_last_ic;
`else
        pick_ic = (m_starve >= LIM);
`endif
        if (bif.ic_req && (!bif.dc_req || pick_ic)) exp_ic = 1;
        else if (bif.dc_req) exp_dc = 1;
      end
      exp_req = (m_active && !m_acc && !m_fin) ? m_op.typ : 3'd0;
      chk("ic_gnt",  BW'(bif.ic_gnt),  BW'(exp_ic));
      chk("dc_gnt",  BW'(bif.dc_gnt),  BW'(exp_dc));
      chk("busy",    BW'(bif.busy),    BW'(m_active));
      chk("bus_req", BW'(bif.bus_req), BW'(exp_req));
      if (exp_req != 3'd0) chk("bus_addr_hold", BW'(bif.bus_addr), BW'(m_op.addr));
      chk("ic_done", BW'(bif.ic_done), BW'(m_fin && !m_owner_dc));
      chk("dc_done", BW'(bif.dc_done), BW'(m_fin && m_owner_dc));

      if (!m_active) begin
        if (exp_ic) begin
          m_op.typ  = bif.ic_blk ? 3'd2 : 3'd1;
          m_op.addr = bif.ic_addr;
          m_op.wblock = '0; m_op.wword = '0; m_op.wstrb = '0;
          m_owner_dc = 0; m_starve = 0; m_last_ic = 1; m_ic_gnts++;
        end else if (exp_dc) begin
          m_op.typ    = 3'(1 + 2 * int'(bif.dc_wr) + int'(bif.dc_blk));
          m_op.addr   = bif.dc_addr;
          m_op.wblock = bif.dc_wblock;
          m_op.wword  = bif.dc_wword;
          m_op.wstrb  = bif.dc_wstrb;
          m_owner_dc = 1; m_last_ic = 0; m_dc_gnts++;
          if (bif.ic_req) m_starve++; else m_starve = 0;
        end else if (!bif.ic_req) begin
          m_starve = 0;
        end
        if (exp_ic || exp_dc) begin
          m_active = 1; m_acc = 0; m_fin = 0;
          bus_q.push_back(m_op);
        end
      end else if (m_fin) begin
        m_active = 0; m_fin = 0;
      end else if (!m_acc) begin
        if (bif.bus_ready) begin
          m_acc = 1;
          fin_now = bif.bus_finish;
        end
      end else begin
        fin_now = bif.bus_finish;
      end
      if (fin_now) begin
        m_fin = 1;
        d.dc = m_owner_dc; d.typ = m_op.typ;
        d.rblock = bif.bus_rblock; d.rword = bif.bus_rword;
        done_q.push_back(d);
      end
    end
  end

  // ---------------- monitor: pops scoreboard on DUT outputs ----------------
  always @(negedge clk) begin
    bus_op_t e;
    done_t   d;
    if (!rst) begin
      if (tie_logging && (bif.ic_gnt || bif.dc_gnt)) gnt_log.push_back(bif.ic_gnt);
      if (bif.bus_req != 3'd0 && bif.bus_ready) begin
        n_checks++;
        if (bus_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_accept: got bus_req %0d, expected no pending operation", bif.bus_req);
        end else begin
          e = bus_q.pop_front();
          chk("op_type", BW'(bif.bus_req),  BW'(e.typ));
          chk("op_addr", BW'(bif.bus_addr), BW'(e.addr));
          if (e.typ == 3'd3) begin
            chk("op_wword", BW'(bif.bus_wword), BW'(e.wword));
            chk("op_wstrb", BW'(bif.bus_wstrb), BW'(e.wstrb));
          end
          if (e.typ == 3'd4) chk("op_wblock", bif.bus_wblock, e.wblock);
        end
      end
      if (bif.ic_done || bif.dc_done) begin
        n_checks++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_pulse: got ic_done=%0b dc_done=%0b, expected none", bif.ic_done, bif.dc_done);
        end else begin
          d = done_q.pop_front();
          chk("done_owner", BW'(bif.dc_done), BW'(d.dc));
          if (d.typ <= 3'd2) begin
            chk("done_rblock", bif.rblock, d.rblock);
            chk("done_rword",  BW'(bif.rword), BW'(d.rword));
          end
          $display("txn %s type=%0d rword=%08h", d.dc ? "dc" : "ic", d.typ, bif.rword);
        end
      end
    end
  end

  // ---------------- bridge model ----------------
  int br_phase = 0;
  int br_cnt   = 0;
  bit br_fast  = 0;
  initial begin
    bif.bus_ready = 0; bif.bus_finish = 0; bif.bus_rblock = '0; bif.bus_rword = '0;
    forever begin
      @(posedge clk); #1;
      bif.bus_ready = 0; bif.bus_finish = 0;
      if (cfg_rdata_fixed) begin
        bif.bus_rblock = {16{8'hA5}};
        bif.bus_rword  = 32'hA5A5A5A5;
      end else begin
        bif.bus_rblock = {$urandom, $urandom, $urandom, $urandom};
        bif.bus_rword  = $urandom;
      end
      if (rst) begin
        br_phase = 0;
      end else begin
        if (br_phase == 0 && bif.bus_req != 3'd0) begin
          br_cnt   = (cfg_rdy < 0) ? int'($urandom_range(0, 3)) : cfg_rdy;
          br_fast  = (cfg_fast < 0) ? ($urandom_range(0, 3) == 0) : (cfg_fast != 0);
          br_phase = 1;
        end
        if (br_phase == 1) begin
          if (br_cnt == 0) begin
            bif.bus_ready = 1;
            if (br_fast) begin
              bif.bus_finish = 1;
              br_phase = 0;
            end else begin
              br_phase = 2;
              br_cnt = (cfg_fin < 0) ? int'($urandom_range(0, 4)) : cfg_fin;
            end
          end else br_cnt--;
        end else if (br_phase == 2) begin
          if (br_cnt == 0) begin
            bif.bus_finish = 1;
            br_phase = 0;
          end else br_cnt--;
        end else if (cfg_noise && bif.bus_req == 3'd0) begin
          // stray handshakes outside ISSUE/WAIT must be ignored
          bif.bus_ready  = ($urandom_range(0, 7) == 0);
          bif.bus_finish = ($urandom_range(0, 7) == 0);
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (m_ic_gnts != ic_taken) begin ic_taken = m_ic_gnts; bif.ic_req = 0; end
      if (m_dc_gnts != dc_taken) begin dc_taken = m_dc_gnts; bif.dc_req = 0; end
      if (!bif.ic_req && int'($urandom_range(0, 99)) < ic_rate) begin
        bif.ic_req  = 1;
        bif.ic_blk  = 1'($urandom);
        bif.ic_addr = $urandom;
      end
      if (!bif.dc_req && int'($urandom_range(0, 99)) < dc_rate) begin
        bif.dc_req    = 1;
        bif.dc_wr     = 1'($urandom);
        bif.dc_blk    = 1'($urandom);
        bif.dc_addr   = $urandom;
        bif.dc_wblock = {$urandom, $urandom, $urandom, $urandom};
        bif.dc_wword  = $urandom;
        bif.dc_wstrb  = 4'($urandom);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((m_active || bif.ic_req || bif.dc_req) && t < 500) begin
      step(1);
      t++;
    end
    n_checks++;
    if (m_active || bif.ic_req || bif.dc_req) begin
      n_fail++;
      $display("FAIL drain: transaction still pending after %0d cycles, expected idle", t);
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1;
    step(n);
    rst = 0;
  endtask

  initial begin
    bit exp_ic;
    int t;
    bif.ic_req = 0; bif.ic_blk = 0; bif.ic_addr = '0;
    bif.dc_req = 0; bif.dc_wr = 0; bif.dc_blk = 0; bif.dc_addr = '0;
    bif.dc_wblock = '0; bif.dc_wword = '0; bif.dc_wstrb = '0;
    step(3);
    rst = 0;

    // tie: both ports request continuously from reset
    cfg_rdy = 0; cfg_fin = 0; cfg_fast = 1;
    ic_rate = 100; dc_rate = 100; tie_logging = 1;
    t = 0;
    while (gnt_log.size() < 18 && t < 400) begin step(1); t++; end
    tie_logging = 0;
    n_checks++;
    if (gnt_log.size() < 18) begin
      n_fail++;
      $display("FAIL tie_grants: got %0d grants, expected 18", gnt_log.size());
    end
    for (int i = 0; i < 18 && i < gnt_log.size(); i++) begin
`ifdef ARB_RR_EN
      exp_ic = (i % 2) == 1;
`else
      exp_ic = (i % (LIM + 1)) == LIM;
`endif
      chk("tie_order", BW'(gnt_log[i]), BW'(exp_ic));
    end
    ic_rate = 0; dc_rate = 0;
    drain();

    // icache block read, finish five cycles after ready
    cfg_rdy = 0; cfg_fin = 4; cfg_fast = 0; cfg_rdata_fixed = 1;
    bif.ic_req = 1; bif.ic_blk = 1; bif.ic_addr = 32'h1C000100;
    drain();
    cfg_rdata_fixed = 0;

    // uncached store with ready+finish in one cycle
    cfg_fast = 1;
    bif.dc_req = 1; bif.dc_wr = 1; bif.dc_blk = 0; bif.dc_addr = 32'h0000_2004;
    bif.dc_wword = 32'hDEADBEEF; bif.dc_wstrb = 4'h3;
    drain();

    // bus_ready held off for 10 cycles; an icache request arrives meanwhile
    cfg_rdy = 10; cfg_fin = 2; cfg_fast = 0;
    bif.dc_req = 1; bif.dc_wr = 0; bif.dc_blk = 1; bif.dc_addr = 32'h0000_3000;
    step(3);
    bif.ic_req = 1; bif.ic_blk = 0; bif.ic_addr = 32'h1C00_0040;
    drain();

    // randomized traffic with stray handshakes
    cfg_rdy = -1; cfg_fin = -1; cfg_fast = -1; cfg_noise = 1;
    for (int seg = 0; seg < 8; seg++) begin
      ic_rate = int'($urandom_range(5, 100));
      dc_rate = int'($urandom_range(5, 100));
      step(250);
    end
    ic_rate = 0; dc_rate = 0; cfg_noise = 0;
    drain();

    // reset while waiting for finish: no done pulse afterwards
    cfg_rdy = 0; cfg_fin = 30; cfg_fast = 0;
    bif.dc_req = 1; bif.dc_wr = 0; bif.dc_blk = 0; bif.dc_addr = 32'h0000_4000;
    t = 0;
    while (!m_acc && t < 50) begin step(1); t++; end
    n_checks++;
    if (!m_acc) begin
      n_fail++;
      $display("FAIL reach_wait: got no bus acceptance within %0d cycles, expected acceptance", t);
    end
    step(2);
    apply_reset(2);
    step(5);
    cfg_fin = 1;
    bif.ic_req = 1; bif.ic_blk = 1; bif.ic_addr = 32'h1C00_0200;
    drain();
    step(3);

    n_checks++;
    if (bus_q.size() != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d ops and %0d dones left, expected 0", bus_q.size(), done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
